// File: rtl/input_pkg.sv
// ============================================================================
// Module      : input_pkg
// Description : Shared button index constants and input-path defaults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package input_pkg;

    // Bit order shared with the input controller's control-state vector
    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_ATTACK = 4;

    localparam int NUM_BUTTONS            = 5;
    localparam int DEFAULT_SYNC_STAGES    = 2;
    localparam int DEFAULT_DEBOUNCE_TICKS = 4;

    typedef logic [NUM_BUTTONS-1:0] button_vec_t;

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// Module      : debounce_channel
// Description : One-bit synchroniser, stable-interval filter and edge strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_tick,
    input  logic button_raw,
    output logic button_clean,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_stable;
    logic                   r_press;
    logic                   r_release;

    logic w_sync;
    logic w_mismatch;
    logic w_accept;
    logic w_next_stable;

    assign w_sync        = r_sync[SYNC_STAGES-1];
    assign w_mismatch    = w_sync ^ r_stable;
    assign w_accept      = w_mismatch & sample_tick & (r_cnt == C_CNT_LAST);
    assign w_next_stable = w_accept ? w_sync : r_stable;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], button_raw};
        end
    end

    // Any return to the stable level restarts the interval
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!w_mismatch || w_accept) begin
            r_cnt <= '0;
        end else if (sample_tick) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stable  <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_stable  <= w_next_stable;
            r_press   <= ~r_stable & w_next_stable;
            r_release <= r_stable & ~w_next_stable;
        end
    end

    assign button_clean  = r_stable;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;

endmodule

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// Module      : button_debouncer
// Description : Debounces the player buttons and emits press/release strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer #(
    parameter int NUM_BUTTONS    = input_pkg::NUM_BUTTONS,
    parameter int SYNC_STAGES    = input_pkg::DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_TICKS = input_pkg::DEFAULT_DEBOUNCE_TICKS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_tick,
    input  logic [NUM_BUTTONS-1:0] buttons_raw,
    output logic [NUM_BUTTONS-1:0] buttons_clean,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic                   any_change
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_channel
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
        ) u_channel (
            .clk           (clk),
            .reset         (reset),
            .sample_tick   (sample_tick),
            .button_raw    (buttons_raw[i]),
            .button_clean  (buttons_clean[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

    // Strobes are registered in the channels, so this stays flop-driven
    assign any_change = (|press_pulse) | (|release_pulse);

endmodule

`default_nettype wire

// File: tb/tb_button_debouncer.sv
// ============================================================================
// Module      : tb_button_debouncer
// Description : Scoreboard bench: expected strobe events queued at stimulus time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_debouncer;

    localparam int NB = 5;
    localparam int SS = 2;
    localparam int DT = 4;
    localparam int TP = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          sample_tick = 1'b0;
    logic [NB-1:0] buttons_raw = '0;
    logic [NB-1:0] buttons_clean;
    logic [NB-1:0] press_pulse;
    logic [NB-1:0] release_pulse;
    logic          any_change;

    typedef struct {
        int            edge_no;
        logic [NB-1:0] mask;
        bit            is_press;
        logic [NB-1:0] clean_after;
    } evt_t;

    evt_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    int            edge_n = 0;
    logic [NB-1:0] cur_clean = '0;
    logic [NB-1:0] model_level = '0;

    button_debouncer #(
        .NUM_BUTTONS    (NB),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_TICKS (DT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .buttons_raw   (buttons_raw),
        .buttons_clean (buttons_clean),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .any_change    (any_change)
    );

    always #5 clk = ~clk;

    // Tick is sampled at every edge whose number is a multiple of TP
    always @(negedge clk) sample_tick = ((edge_n + 1) % TP == 0);

    // Edge that samples the DT-th tick once the raw level first sampled at e0 reaches sync
    function automatic int accept_edge(input int e0);
        int n = 0;
        for (int e = e0 + SS; e < e0 + SS + TP * (DT + 1); e++) begin
            if (e % TP == 0) begin
                n++;
                if (n == DT) return e;
            end
        end
        return -1;
    endfunction

    task automatic push_evt(input logic [NB-1:0] mask, input bit is_press);
        evt_t ev;
        model_level    = is_press ? (model_level | mask) : (model_level & ~mask);
        ev.edge_no     = accept_edge(edge_n + 1);
        ev.mask        = mask;
        ev.is_press    = is_press;
        ev.clean_after = model_level;
        sb.push_back(ev);
    endtask

    always @(posedge clk) begin
        logic          rst_s;
        logic [NB-1:0] ep;
        logic [NB-1:0] er;
        logic          ea;
        evt_t          ev;
        edge_n++;
        rst_s = reset;
        #1;
        ep = '0;
        er = '0;
        if (!rst_s) begin
            cur_clean = '0;
        end else if (sb.size() > 0 && sb[0].edge_no == edge_n) begin
            ev = sb.pop_front();
            if (ev.is_press) ep = ev.mask;
            else             er = ev.mask;
            cur_clean = ev.clean_after;
        end
        ea = (ep != '0) || (er != '0);
        checks++;
        if (press_pulse !== ep) begin
            errors++;
            $display("FAIL press edge=%0d got=%b want=%b", edge_n, press_pulse, ep);
        end
        checks++;
        if (release_pulse !== er) begin
            errors++;
            $display("FAIL release edge=%0d got=%b want=%b", edge_n, release_pulse, er);
        end
        checks++;
        if (any_change !== ea) begin
            errors++;
            $display("FAIL any_change edge=%0d got=%b want=%b", edge_n, any_change, ea);
        end
        checks++;
        if (buttons_clean !== cur_clean) begin
            errors++;
            $display("FAIL clean edge=%0d got=%b want=%b", edge_n, buttons_clean, cur_clean);
        end
    end

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL %s timeout pending=%0d want=0", name, sb.size());
            sb.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic release_all(input string name);
        @(negedge clk);
        buttons_raw = '0;
        if (model_level != '0) push_evt(model_level, 1'b0);
        wait_idle(name, 100);
    endtask

    task automatic test_reset;
        reset       = 1'b0;
        buttons_raw = 5'b11111;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        push_evt(5'b11111, 1'b1);
        wait_idle("reset_press", 100);
        release_all("reset_release");
    endtask

    task automatic test_clean_press;
        @(negedge clk);
        buttons_raw[0] = 1'b1;
        push_evt(5'b00001, 1'b1);
        wait_idle("clean_press", 100);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_bounce;
        @(negedge clk);
        buttons_raw[4] = 1'b1;
        repeat (2 * TP) @(negedge clk);
        buttons_raw[4] = 1'b0;
        repeat (2 * TP) @(negedge clk);
        buttons_raw[4] = 1'b1;
        push_evt(5'b10000, 1'b1);
        wait_idle("bounce", 100);
    endtask

    task automatic test_glitch;
        @(negedge clk);
        buttons_raw[2] = 1'b1;
        push_evt(5'b00100, 1'b1);
        wait_idle("glitch_press", 100);
        buttons_raw[2] = 1'b0;
        repeat (3 * TP) @(negedge clk);
        buttons_raw[2] = 1'b1;
        repeat (6 * TP) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        buttons_raw[1] = 1'b1;
        buttons_raw[3] = 1'b1;
        push_evt(5'b01010, 1'b1);
        wait_idle("simul_press", 100);
        buttons_raw[1] = 1'b0;
        buttons_raw[3] = 1'b0;
        push_evt(5'b01010, 1'b0);
        wait_idle("simul_release", 100);
    endtask

    task automatic test_reset_mid;
        release_all("mid_prep");
        buttons_raw[0] = 1'b1;
        push_evt(5'b00001, 1'b1);
        repeat (18) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        model_level = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        push_evt(5'b00001, 1'b1);
        wait_idle("reset_mid", 100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/button_debouncer.md
# button_debouncer

Conditions the five raw player buttons (up, down, left, right, attack) before they reach the input controller. Each button is synchronised into `clk` and held to a stable-interval filter, so the controller's edge detector only sees clean level changes. It also emits one-cycle press and release strobes for other consumers. It sits between the top-level `ui_in` pins and the input controller's `up`/`down`/`left`/`right`/`attack` inputs.

## Interface
- `NUM_BUTTONS`, 5: number of independent channels; bit order is up, down, left, right, attack (bits 0..4).
- `SYNC_STAGES`, 2: synchroniser depth, minimum 2.
- `DEBOUNCE_TICKS`, 4: number of consecutive `sample_tick` strobes a new level must persist before it is accepted, minimum 1.
- `CNT_W`, $clog2(DEBOUNCE_TICKS+1): counter width, derived, not overridden.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low.
- `sample_tick` in 1: single-cycle enable strobe from the timebase (nominally 1 kHz); sets the debounce granularity.
- `buttons_raw` in NUM_BUTTONS: asynchronous button levels, 1 = pressed.
- `buttons_clean` out NUM_BUTTONS: debounced, registered levels; drives the input controller.
- `press_pulse` out NUM_BUTTONS: 1-cycle strobe when the corresponding `buttons_clean` bit rises.
- `release_pulse` out NUM_BUTTONS: 1-cycle strobe when the corresponding `buttons_clean` bit falls.
- `any_change` out 1: OR of all press and release strobes in the same cycle.

## Operation
- Each channel runs the same logic, with no interaction between channels.
- **Synchroniser:** `SYNC_STAGES` flops shift `buttons_raw[i]` in every cycle. The last stage is `sync[i]`.
- **Filter state per channel:** `stable[i]` drives `buttons_clean[i]` directly. `cnt[i]` has width CNT_W.
- **Mismatch** means `sync[i] != stable[i]`:
  - Mismatch, `sample_tick` = 1, and `cnt == DEBOUNCE_TICKS-1`: `stable <= sync`, `cnt <= 0`.
  - Mismatch, `sample_tick` = 1, otherwise: `cnt <= cnt + 1`.
  - Mismatch, `sample_tick` = 0: `cnt` holds.
  - No mismatch: `cnt <= 0` immediately, regardless of `sample_tick`. Any bounce back to the stable level restarts the interval.
- **Counter range:** `cnt` never exceeds DEBOUNCE_TICKS-1 and never wraps.
- **Strobes:** `press_pulse[i] <= ~stable[i] & next_stable[i]` and `release_pulse[i] <= stable[i] & ~next_stable[i]`, both registered.
  - Each strobe is high for exactly one cycle, in the same cycle `buttons_clean` first shows the new level.
- **DEBOUNCE_TICKS = 1:** the level is accepted on the first `sample_tick` that sees a mismatch.
- **Simultaneous events:** multiple channels may change in the same cycle. Each strobes independently and `any_change` is 1 once.
- **Reset (`reset` == 0 at a rising edge):**
  - Synchroniser flops, `stable`, `cnt`, `buttons_clean`, `press_pulse`, `release_pulse` and `any_change` all go to 0.
  - Reset takes priority over `sample_tick`.
  - Reset mid-interval discards partial counts.
  - A button still held when reset is released must be re-debounced for the full interval, then produces a `press_pulse`.

## Timing
- **Synchroniser latency:** a raw change at edge E reaches `sync` at edge E+SYNC_STAGES.
- **Acceptance:** `buttons_clean` changes at the edge that samples the DEBOUNCE_TICKS-th qualifying `sample_tick`. That is, the Nth tick counted after mismatch began, with no intervening match.
- **Minimum latency, raw to clean:** SYNC_STAGES + 1 cycles, reached when DEBOUNCE_TICKS = 1 and the tick is coincident.
- **Maximum latency:** SYNC_STAGES + DEBOUNCE_TICKS × tick period + 1 cycles.
- **Strobe alignment:** strobes and `any_change` are coincident with the `buttons_clean` change and last 1 cycle.
- **Downstream edge detection:** downstream sees at most one clean edge per DEBOUNCE_TICKS tick periods per button.
- **Outputs:** all outputs are registered, with no combinational path from inputs to outputs.

## Structure
- **Shared package `input_pkg`:**
  - Button index constants `BTN_UP`=0, `BTN_DOWN`=1, `BTN_LEFT`=2, `BTN_RIGHT`=3, `BTN_ATTACK`=4.
  - `NUM_BUTTONS`=5.
  - Default `DEBOUNCE_TICKS`.
  - The input controller uses the same constants for its control-state bit order.
- **Sub-module `debounce_channel`:**
  - Contains the synchroniser, counter, stable flop and strobe flops for one bit.
  - Parameters `SYNC_STAGES` and `DEBOUNCE_TICKS`.
  - Instantiated `NUM_BUTTONS` times in a generate loop.
  - The top level only ORs the strobes into `any_change`.

## Test plan
All scenarios use `SYNC_STAGES`=2, `DEBOUNCE_TICKS`=4 and `sample_tick` every 8 cycles.

1. **Reset:** hold `reset`=0 for 3 cycles with `buttons_raw`=5'b11111 → all outputs 0 during reset.
   - After release, `buttons_clean` becomes 5'b11111 only after 4 ticks.
   - `press_pulse`=5'b11111 for exactly 1 cycle and `any_change`=1 for that cycle.
2. **Clean press:** `buttons_raw[0]` steps 0→1 and is held → `buttons_clean[0]` rises at the edge sampling the 4th tick after `sync` mismatch.
   - `press_pulse[0]`=1 for 1 cycle.
   - No other bit changes.
3. **Bounce:** toggle `buttons_raw[4]` 1,0,1 with each level lasting 2 ticks, then hold 1 → `cnt` restarts on each return to 0.
   - `buttons_clean[4]` rises only 4 ticks after the final 0→1.
   - Exactly one `press_pulse[4]`.
4. **Glitch rejection:** with `buttons_clean[2]`=1, drop `buttons_raw[2]` to 0 for 3 ticks, then return to 1 → `buttons_clean[2]` stays 1.
   - No `release_pulse` occurs.
5. **Simultaneous release:** with buttons 1 and 3 held and clean, drop both in the same cycle → `release_pulse`=5'b01010 in one cycle.
   - `any_change`=1 for 1 cycle.
   - `buttons_clean` shows 5'b00000 for those bits from the same cycle.
6. **Reset mid-interval:** press button 0, assert `reset`=0 after 2 ticks, release reset with the button still held → no output activity before reset.
   - `buttons_clean[0]` rises 4 ticks after reset release, with one `press_pulse[0]`.
